ldtu_hamm_ofifo_param: RTL and testbench

//  Parametrised storage FIFO between the Hamming encoder and the output serialiser/decoder path.

---
 rtl/ldtu_pkg.sv | 11 +
 rtl/ldtu_fifo_mem.sv | 24 ++
 rtl/ldtu_hamm_ofifo_param.sv | 98 +++++++++
 tb/tb_ldtu_hamm_ofifo_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ldtu_pkg.sv
// Shared LiTe-DTU constants: Hamming word width, idle pattern and FIFO defaults.
package ldtu_pkg;

  localparam int              NBITS_HAM      = 38;
  localparam logic [37:0]     IDLE_WORD      = 38'h0040000000;
  localparam int              FIFO_DEPTH     = 16;
  localparam int              FIFO_PTR_BITS  = 4;
  localparam int              FIFO_AFULL_TH  = 12;
  localparam int              FIFO_AEMPTY_TH = 2;

endpackage

// File: rtl/ldtu_fifo_mem.sv
// DEPTH x NBITS storage array: synchronous write, combinational read address.
module ldtu_fifo_mem #(
  parameter int NBITS    = 38,
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = 4
) (
  input  logic                CLK,
  input  logic                we,
  input  logic [PTR_BITS-1:0] waddr,
  input  logic [NBITS-1:0]    wdata,
  input  logic [PTR_BITS-1:0] raddr,
  output logic [NBITS-1:0]    rdata
);

  logic [NBITS-1:0] mem [DEPTH];

  // Contents are never reset; the pointers decide what is valid.
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ldtu_hamm_ofifo_param.sv
// Output FIFO between the Hamming encoder and the serialiser: full-depth usage,
// occupancy count, threshold flags, sticky overflow/underflow, registered read port.
module ldtu_hamm_ofifo_param
  import ldtu_pkg::*;
#(
  parameter int               NBITS     = NBITS_HAM,
  parameter int               DEPTH     = FIFO_DEPTH,
  parameter int               PTR_BITS  = FIFO_PTR_BITS,
  parameter int               AFULL_TH  = FIFO_AFULL_TH,
  parameter int               AEMPTY_TH = FIFO_AEMPTY_TH,
  parameter logic [NBITS-1:0] IDLE_WORD = ldtu_pkg::IDLE_WORD
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                start_write,
  input  logic [NBITS-1:0]    data_input,
  input  logic                read_signal,
  input  logic                clr_flags,
  output logic [NBITS-1:0]    data_output,
  output logic                decode_signal,
  output logic                empty_signal,
  output logic                full_signal,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [PTR_BITS:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [PTR_BITS:0] AFULL_C  = (PTR_BITS+1)'(AFULL_TH);
  localparam logic [PTR_BITS:0] AEMPTY_C = (PTR_BITS+1)'(AEMPTY_TH);

  logic [PTR_BITS:0]  wr_ptr;
  logic [PTR_BITS:0]  rd_ptr;
  logic [NBITS-1:0]   rd_data;
  logic               wr_acc;
  logic               rd_acc;

  // Extra wrap bit distinguishes full from empty when the addresses coincide.
  assign full_signal  = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                        (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
  assign empty_signal = (wr_ptr == rd_ptr);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  assign wr_acc = start_write & ~full_signal;
  assign rd_acc = read_signal & ~empty_signal;

  ldtu_fifo_mem #(
    .NBITS    (NBITS),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_mem (
    .CLK   (CLK),
    .we    (wr_acc),
    .waddr (wr_ptr[PTR_BITS-1:0]),
    .wdata (data_input),
    .raddr (rd_ptr[PTR_BITS-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_output   <= IDLE_WORD;
      decode_signal <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;

      if (rd_acc) begin
        rd_ptr        <= rd_ptr + 1'b1;
        data_output   <= rd_data;
        decode_signal <= 1'b1;
      end else begin
        data_output   <= IDLE_WORD;
        decode_signal <= 1'b0;
      end

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A new error event in the same cycle as a clear keeps the flag set.
      if (start_write & full_signal) overflow <= 1'b1;
      else if (clr_flags)            overflow <= 1'b0;

      if (read_signal & empty_signal) underflow <= 1'b1;
      else if (clr_flags)             underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ldtu_hamm_ofifo_param.sv
// Scoreboard bench for ldtu_hamm_ofifo_param: reference queue model, decoupled output monitor.
module tb_ldtu_hamm_ofifo_param;

  localparam logic [37:0] IDLE = 38'h0040000000;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start_write;
  logic [37:0] data_input;
  logic        read_signal;
  logic        clr_flags;
  logic [37:0] data_output;
  logic        decode_signal;
  logic        empty_signal;
  logic        full_signal;
  logic        almost_empty;
  logic        almost_full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;

  logic [37:0] ref_q[$];
  logic [37:0] exp_q[$];
  bit          m_ovf;
  bit          m_unf;

  ldtu_hamm_ofifo_param dut (
    .CLK           (CLK),
    .reset         (reset),
    .start_write   (start_write),
    .data_input    (data_input),
    .read_signal   (read_signal),
    .clr_flags     (clr_flags),
    .data_output   (data_output),
    .decode_signal (decode_signal),
    .empty_signal  (empty_signal),
    .full_signal   (full_signal),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = ref_q.size();
    cmp({tag, ".count"},     64'(count),        64'(n));
    cmp({tag, ".empty"},     64'(empty_signal), 64'(n == 0));
    cmp({tag, ".full"},      64'(full_signal),  64'(n == 16));
    cmp({tag, ".a_empty"},   64'(almost_empty), 64'(n <= 2));
    cmp({tag, ".a_full"},    64'(almost_full),  64'(n >= 12));
    cmp({tag, ".overflow"},  64'(overflow),     64'(m_ovf));
    cmp({tag, ".underflow"}, 64'(underflow),    64'(m_unf));
  endtask

  // Check the state left by the previous edge, drive the next vector, advance the model.
  task automatic step(input string tag, input logic w, input logic [37:0] d,
                      input logic r, input logic c);
    bit full_now, empty_now;
    @(negedge CLK);
    check_state(tag);
    start_write = w;
    data_input  = d;
    read_signal = r;
    clr_flags   = c;
    full_now  = (ref_q.size() == 16);
    empty_now = (ref_q.size() == 0);
    if (r && !empty_now) exp_q.push_back(ref_q.pop_front());
    if (w && !full_now)  ref_q.push_back(d);
    if (w && full_now)   m_ovf = 1'b1;
    else if (c)          m_ovf = 1'b0;
    if (r && empty_now)  m_unf = 1'b1;
    else if (c)          m_unf = 1'b0;
  endtask

  // Monitor: every popped word must match the scoreboard head; otherwise the port idles.
  always @(posedge CLK) begin
    #1;
    if (!reset) begin
      if (decode_signal) begin
        if (exp_q.size() == 0) begin
          cmp("mon.unexpected_decode", 64'(data_output), 64'(IDLE));
        end else begin
          cmp("mon.data", 64'(data_output), 64'(exp_q.pop_front()));
        end
      end else begin
        cmp("mon.idle_word", 64'(data_output), 64'(IDLE));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_write = 1'b0; data_input = '0; read_signal = 1'b0; clr_flags = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    cmp("rst.count", 64'(count), 64'd0);
    cmp("rst.empty", 64'(empty_signal), 64'd1);
    @(negedge CLK) reset = 1'b0;

    // Reset asserted mid-cycle while a popped word is being presented
    step("t1.w0", 1, 38'h3FFFFFFFFF, 0, 0);
    step("t1.w1", 1, 38'h0123456789, 0, 0);
    step("t1.w2", 1, 38'h2AAAAAAAAA, 0, 0);
    step("t1.r0", 0, '0, 1, 0);
    @(posedge CLK);
    #3 reset = 1'b1;
    #1;
    cmp("t1.async.data",   64'(data_output),   64'(IDLE));
    cmp("t1.async.empty",  64'(empty_signal),  64'd1);
    cmp("t1.async.count",  64'(count),         64'd0);
    cmp("t1.async.decode", 64'(decode_signal), 64'd0);
    start_write = 1'b0; read_signal = 1'b0;
    ref_q.delete(); exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge CLK) reset = 1'b0;
    step("t1.idle", 0, '0, 0, 0);

    // Fill to full, then one write too many
    for (int i = 0; i < 16; i++) step("t2.wr", 1, 38'(i), 0, 0);
    step("t2.ovf", 1, 38'h1111, 0, 0);
    step("t2.chk", 0, '0, 0, 0);

    // Drain in order, then one read too many
    for (int i = 0; i < 16; i++) step("t3.rd", 0, '0, 1, 0);
    step("t3.unf", 0, '0, 1, 0);
    step("t3.chk", 0, '0, 0, 0);

    // clr_flags alone clears both sticky flags
    step("t6.clr", 0, '0, 0, 1);
    step("t6.chk", 0, '0, 0, 0);

    // Hold 8 entries while streaming through the pointer wrap
    for (int i = 0; i < 8; i++)  step("t4.fill", 1, 38'h100 + 38'(i), 0, 0);
    for (int i = 0; i < 40; i++) step("t4.rw",   1, 38'h200 + 38'(i), 1, 0);

    // Full with simultaneous read+write: read taken, write dropped
    for (int i = 0; i < 8; i++) step("t5.fill", 1, 38'h300 + 38'(i), 0, 0);
    step("t5.rw_full", 1, 38'h3FF, 1, 0);
    step("t5.chk", 0, '0, 0, 0);

    // Clear, then overflow coinciding with clr_flags keeps the flag
    step("t6.clr2", 0, '0, 0, 1);
    step("t6.refill", 1, 38'h400, 0, 0);
    step("t6.ovf_clr", 1, 38'h401, 0, 1);
    step("t6.chk2", 0, '0, 0, 0);

    // Drain, then read+write while empty: write taken, read rejected
    for (int i = 0; i < 16; i++) step("t7.rd", 0, '0, 1, 0);
    step("t7.rw_empty", 1, 38'h2BADC0FFEE, 1, 0);
    step("t7.rd_last", 0, '0, 1, 0);
    step("t7.idle", 0, '0, 0, 0);
    step("t7.end", 0, '0, 0, 0);

    @(negedge CLK);
    cmp("end.scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
